// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bit.
// One bit per clk cycle; outputs are registered and track the state entered on each edge.
module uart_tx_frame #(
   parameter int Data_size = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [Data_size-1:0] P_DATA,
   input  logic                 Data_Valid,
   input  logic                 PAR_EN,
   input  logic                 PAR_TYP,
   output logic                 TX_OUT,
   output logic                 busy
);

   // state  | meaning
   // IDLE   | line high, waiting for Data_Valid
   // START  | driving start bit (0)
   // DATA   | shifting out data bits LSB first
   // PARITY | driving latched parity bit
   // STOP   | driving stop bit (1), last busy cycle
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam int CW = $clog2(Data_size);
   localparam logic [CW-1:0] LAST = CW'(Data_size - 1);

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [Data_size-1:0] shreg, shreg_nxt;
   logic                 par_bit, par_bit_nxt;
   logic                 par_en_q, par_en_nxt;
   logic                 tx_nxt, busy_nxt;

   // Outputs are computed for the state being entered so they change on the same edge.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      shreg_nxt   = shreg;
      par_bit_nxt = par_bit;
      par_en_nxt  = par_en_q;
      tx_nxt      = 1'b1;
      busy_nxt    = 1'b1;
      case (state)
         S_IDLE: begin
            busy_nxt = 1'b0;
            if (Data_Valid) begin
               state_nxt   = S_START;
               shreg_nxt   = P_DATA;
               par_en_nxt  = PAR_EN;
               par_bit_nxt = PAR_TYP ? ~^P_DATA : ^P_DATA;
               cnt_nxt     = '0;
               tx_nxt      = 1'b0;
               busy_nxt    = 1'b1;
            end
         end
         S_START: begin
            state_nxt = S_DATA;
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
         end
         S_DATA: begin
            if (cnt == LAST) begin
               cnt_nxt = '0;
               if (par_en_q) begin
                  state_nxt = S_PARITY;
                  tx_nxt    = par_bit;
               end else begin
                  state_nxt = S_STOP;
               end
            end else begin
               cnt_nxt   = cnt + CW'(1);
               tx_nxt    = shreg[0];
               shreg_nxt = shreg >> 1;
            end
         end
         S_PARITY: begin
            state_nxt = S_STOP;
         end
         S_STOP: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         par_en_q <= 1'b0;
         TX_OUT   <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         shreg    <= shreg_nxt;
         par_bit  <= par_bit_nxt;
         par_en_q <= par_en_nxt;
         TX_OUT   <= tx_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-computed bit sequences plus a loopback receiver model.
// Sequence vectors hold the expected TX_OUT of frame cycle i in bit i.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_frame #(.Data_size(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_frame(input logic [7:0] d, input logic pen, input logic ptyp);
      P_DATA     = d;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      Data_Valid = 1'b1;
   endtask

   // Checks n frame cycles and the idle cycle after; poke[i] pulses a 0xFF request in cycle i.
   task automatic check_frame(input string tag, input logic [10:0] exp, input int n,
                              input logic [10:0] poke);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         Data_Valid = 1'b0;
         chk($sformatf("%s_tx%0d", tag, i), TX_OUT, exp[i]);
         chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
         if (poke[i]) begin
            Data_Valid = 1'b1;
            P_DATA     = 8'hFF;
            PAR_EN     = ~PAR_EN;
            PAR_TYP    = ~PAR_TYP;
         end
      end
      @(negedge clk);
      Data_Valid = 1'b0;
      chk($sformatf("%s_idle_tx", tag), TX_OUT, 1'b1);
      chk($sformatf("%s_idle_busy", tag), busy, 1'b0);
   endtask

   // Receiver model: deserialize the line, check framing and parity independently.
   task automatic loopback(input logic [7:0] d, input logic pen, input logic ptyp);
      logic [10:0] seq;
      int          n;
      int          ones;
      logic        busy_ok;
      logic        par_err;
      seq     = '0;
      busy_ok = 1'b1;
      n       = pen ? 11 : 10;
      start_frame(d, pen, ptyp);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         Data_Valid = 1'b0;
         seq[i]     = TX_OUT;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      @(negedge clk);
      if (busy !== 1'b0 || TX_OUT !== 1'b1) busy_ok = 1'b0;
      ones = 0;
      for (int b = 1; b <= 8; b++) ones += int'(seq[b]);
      par_err = 1'b0;
      if (pen) begin
         ones += int'(seq[9]);
         par_err = ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1);
      end
      chk($sformatf("lb_data_%02h_%0d%0d", d, pen, ptyp), seq[8:1], d);
      chk($sformatf("lb_par_err_%02h_%0d%0d", d, pen, ptyp), par_err, 1'b0);
      chk($sformatf("lb_framing_%02h_%0d%0d", d, pen, ptyp),
          {seq[0], seq[n-1], busy_ok}, 3'b011);
   endtask

   initial begin
      rst        = 1'b0;
      Data_Valid = 1'b0;
      P_DATA     = 8'h00;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_tx", TX_OUT, 1'b1);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst_tx%0d", i), TX_OUT, 1'b1);
         chk($sformatf("post_rst_busy%0d", i), busy, 1'b0);
      end

      start_frame(8'hA5, 1'b0, 1'b0);
      check_frame("a5_nopar", 11'h34A, 10, 11'h000);

      start_frame(8'hA5, 1'b1, 1'b0);
      check_frame("a5_even", 11'h54A, 11, 11'h000);
      start_frame(8'hA5, 1'b1, 1'b1);
      check_frame("a5_odd", 11'h74A, 11, 11'h000);
      start_frame(8'h01, 1'b1, 1'b0);
      check_frame("01_even", 11'h602, 11, 11'h000);

      // Requests during data bit 3 and during STOP must be dropped; the next one sent after one idle cycle.
      start_frame(8'h3C, 1'b0, 1'b0);
      check_frame("3c_poked", 11'h278, 10, 11'h210);
      start_frame(8'hFF, 1'b0, 1'b0);
      check_frame("ff_after", 11'h3FE, 10, 11'h000);

      start_frame(8'h55, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         logic [5:0] pre;
         pre = 6'b101010;
         @(negedge clk);
         Data_Valid = 1'b0;
         chk($sformatf("55_pre_tx%0d", i), TX_OUT, pre[i]);
      end
      rst        = 1'b0;
      Data_Valid = 1'b1;
      P_DATA     = 8'h00;
      @(negedge clk);
      Data_Valid = 1'b0;
      chk("abort_tx", TX_OUT, 1'b1);
      chk("abort_busy", busy, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_dropped_tx", TX_OUT, 1'b1);
      chk("abort_dropped_busy", busy, 1'b0);
      start_frame(8'h0F, 1'b1, 1'b0);
      check_frame("0f_even", 11'h41E, 11, 11'h000);

      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 256; w++) begin
            loopback(8'($urandom_range(0, 255)), c[1], c[0]);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit serializer. It is the transmit-side counterpart of the existing RX path: same frame format and the same parity convention as the RX parity checker. It accepts a parallel word with a single-cycle valid strobe and emits start bit, data bits LSB first, an optional parity bit and a stop bit on TX_OUT. Each bit lasts one clk cycle; the bit-rate clock is generated upstream. It sits in the UART top beside the RX path and shares the PAR_EN/PAR_TYP configuration.

Parameters:
Data_size, 8, data word width in bits (≥2)

Ports:
clk  input  1  bit-rate clock; all logic on rising edge
rst  input  1  synchronous reset, active-low; sampled on rising edge of clk
P_DATA  input  Data_size  parallel word to send
Data_Valid  input  1  one-cycle request strobe; honoured only when busy=0
PAR_EN  input  1  1 = insert parity bit after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line; idle-high
busy  output  1  high while a frame is in progress

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-low: rst=0 at a rising edge forces state IDLE, TX_OUT=1, busy=0, bit counter=0, shift register=0. All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. If Data_Valid=1 at an edge:
  - latch P_DATA, PAR_EN and PAR_TYP;
  - compute parity bit = ^P_DATA for PAR_TYP=0, ~^P_DATA for PAR_TYP=1;
  - go to START.
- START: TX_OUT=0, busy=1 for 1 cycle, then DATA.
- DATA: TX_OUT = latched bit[k], k=0..Data_size-1, LSB first, one cycle each. The counter wraps to 0 after bit Data_size-1. Next state is PARITY if latched PAR_EN=1, otherwise STOP.
- PARITY: TX_OUT = latched parity bit, busy=1 for 1 cycle, then STOP.
- STOP: TX_OUT=1, busy=1 for 1 cycle, then IDLE.
- Latency: Data_Valid sampled at edge N gives TX_OUT=0 and busy=1 from edge N+1.
- Frame length: Data_size+2 cycles without parity; Data_size+3 with parity. busy falls at the edge ending the STOP cycle.
- Data_Valid while busy=1, including the STOP cycle, is ignored and not queued. The earliest next acceptance is the first IDLE cycle, so there is at least 1 idle-high cycle between frames.
- P_DATA, PAR_EN and PAR_TYP changes mid-frame have no effect on the frame in progress.
- rst=0 mid-frame aborts immediately: next cycle TX_OUT=1, busy=0. No partial frame resumes.
- Data_Valid=1 in the same cycle as rst=0: reset wins and the word is dropped.

Test Plan:
1. Reset: rst=0 for 2 cycles → TX_OUT=1, busy=0. Release reset with Data_Valid=0 for 5 cycles → outputs unchanged.
2. P_DATA=0xA5, PAR_EN=0, Data_Valid pulse → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. busy high for exactly 10 cycles, starting the cycle after the strobe.
3. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 → parity bit 0 (11 bits total). Repeat with PAR_TYP=1 → parity bit 1. Repeat with P_DATA=0x01, PAR_TYP=0 → parity bit 1.
4. Start 0x3C, then pulse Data_Valid with P_DATA=0xFF at data bit 3 and again during STOP → 0x3C frame is intact and no 0xFF frame is sent. Pulse again in IDLE → 0xFF is sent with 1 idle cycle between frames.
5. Mid-frame reset: start 0x55 with parity, assert rst=0 during data bit 4 → TX_OUT=1 and busy=0 next cycle. Release reset and send 0x0F → correct full frame.
6. Loopback: drive TX_OUT into the existing UART RX for 256 random words × {PAR_EN, PAR_TYP} combinations → received P_DATA matches and par_err stays 0 for every frame.
